// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - scalar-core types shared with the vector launcher
package core_pkg;

    localparam int unsigned InsnIdW = 4;

    typedef logic [InsnIdW-1:0] insn_id_t;

endpackage

// File: rtl/rvv_pkg.sv
// rtl/rvv_pkg.sv - vector issue request, in-flight entry and hazard helper
package rvv_pkg;

    import core_pkg::*;

    typedef logic [4:0] vreg_t;

    typedef enum logic [2:0] {
        VADD = 3'd0,
        VSUB = 3'd1,
        VMUL = 3'd2,
        VLE  = 3'd3,
        VSE  = 3'd4
    } vop_e;

    typedef struct packed {
        vop_e        vop;
        vreg_t       vs1;
        vreg_t       vs2;
        vreg_t       vd;
        logic [1:0]  use_vs;
        logic        use_vd;
        logic [1:0]  vew;
        logic [7:0]  vlb;
        logic [31:0] scalar_op;
        insn_id_t    insn_id;
        logic        flip_bit;
    } issue_req_t;

    typedef struct packed {
        insn_id_t   insn_id;
        vreg_t      vd;
        logic       use_vd;
        vreg_t      vs1;
        vreg_t      vs2;
        logic [1:0] use_vs;
        logic       done;
        logic       valid;
    } inflight_entry_t;

    // Loads and stores go to the memory unit, everything else to arithmetic.
    function automatic logic is_mem_op(vop_e op);
        return (op == VLE) || (op == VSE);
    endfunction

    // RAW, WAW or WAR between an in-flight entry and the pending request.
    function automatic logic entry_conflict(inflight_entry_t e, vreg_t vs1, vreg_t vs2,
                                            vreg_t vd, logic [1:0] use_vs, logic use_vd);
        logic raw;
        logic waw;
        logic war;
        raw = e.use_vd && ((use_vs[0] && (e.vd == vs1)) || (use_vs[1] && (e.vd == vs2)));
        waw = e.use_vd && use_vd && (e.vd == vd);
        war = use_vd && ((e.use_vs[0] && (e.vs1 == vd)) || (e.use_vs[1] && (e.vs2 == vd)));
        return raw || waw || war;
    endfunction

endpackage

// File: rtl/vinsn_scoreboard.sv
// rtl/vinsn_scoreboard.sv - in-order in-flight table with done marking, retire and hazard check (RVV_LAUNCHER_FLIP_CHECK_EN adds bad_done_o)
module vinsn_scoreboard
    import core_pkg::*;
    import rvv_pkg::*;
#(
    parameter  int unsigned NrSlots = 4,
    localparam int unsigned SlotW   = $clog2(NrSlots)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fire_i,
    input  insn_id_t         lr_insn_id_i,
    input  vreg_t            lr_vs1_i,
    input  vreg_t            lr_vs2_i,
    input  vreg_t            lr_vd_i,
    input  logic [1:0]       lr_use_vs_i,
    input  logic             lr_use_vd_i,
    input  logic             arith_done_i,
    input  logic [SlotW-1:0] arith_done_slot_i,
    input  logic             mem_done_i,
    input  logic [SlotW-1:0] mem_done_slot_i,
    output logic             hazard_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [SlotW-1:0] tail_o,
`ifdef RVV_LAUNCHER_FLIP_CHECK_EN
    output logic             bad_done_o,
`endif
    output logic             commit_valid_o,
    output insn_id_t         commit_insn_id_o
);

    inflight_entry_t entry_q [NrSlots];
    inflight_entry_t entry_d [NrSlots];
    logic [SlotW-1:0] head_q, head_d;
    logic [SlotW-1:0] tail_q, tail_d;
    logic [SlotW:0]   count_q, count_d;
    logic             commit_valid_q, commit_valid_d;
    insn_id_t         commit_id_q, commit_id_d;
    logic             retire;

    assign full_o           = (count_q == (SlotW+1)'(NrSlots));
    assign empty_o          = (count_q == '0);
    assign tail_o           = tail_q;
    assign commit_valid_o   = commit_valid_q;
    assign commit_insn_id_o = commit_id_q;

`ifdef RVV_LAUNCHER_FLIP_CHECK_EN
    assign bad_done_o = (arith_done_i && !entry_q[arith_done_slot_i].valid) ||
                        (mem_done_i   && !entry_q[mem_done_slot_i].valid);
`endif

    // Hazard against registered, still-pending entries only.
    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < NrSlots; i++) begin
            if (entry_q[i].valid && !entry_q[i].done &&
                entry_conflict(entry_q[i], lr_vs1_i, lr_vs2_i, lr_vd_i, lr_use_vs_i, lr_use_vd_i)) begin
                hazard_o = 1'b1;
            end
        end
    end

    // Next table state: mark completions, retire the head, append the fired request.
    always_comb begin
        entry_d        = entry_q;
        head_d         = head_q;
        tail_d         = tail_q;
        commit_id_d    = commit_id_q;
        retire         = entry_q[head_q].valid && entry_q[head_q].done;
        commit_valid_d = retire;
        if (arith_done_i && entry_q[arith_done_slot_i].valid) begin
            entry_d[arith_done_slot_i].done = 1'b1;
        end
        if (mem_done_i && entry_q[mem_done_slot_i].valid) begin
            entry_d[mem_done_slot_i].done = 1'b1;
        end
        if (retire) begin
            commit_id_d           = entry_q[head_q].insn_id;
            entry_d[head_q].valid = 1'b0;
            head_d                = head_q + SlotW'(1);
        end
        if (fire_i) begin
            entry_d[tail_q].insn_id = lr_insn_id_i;
            entry_d[tail_q].vd      = lr_vd_i;
            entry_d[tail_q].use_vd  = lr_use_vd_i;
            entry_d[tail_q].vs1     = lr_vs1_i;
            entry_d[tail_q].vs2     = lr_vs2_i;
            entry_d[tail_q].use_vs  = lr_use_vs_i;
            entry_d[tail_q].done    = 1'b0;
            entry_d[tail_q].valid   = 1'b1;
            tail_d                  = tail_q + SlotW'(1);
        end
        count_d = count_q + (SlotW+1)'(fire_i) - (SlotW+1)'(retire);
    end

    // Table registers; only the control bits of each entry are reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrSlots; i++) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].done  <= 1'b0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
        end else begin
            entry_q        <= entry_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
        end
    end

endmodule

// File: rtl/vinsn_launcher.sv
// rtl/vinsn_launcher.sv - launch register, unit dispatch and optional flip-bit checker (RVV_LAUNCHER_FLIP_CHECK_EN)
module vinsn_launcher
    import core_pkg::*;
    import rvv_pkg::*;
#(
    parameter  int unsigned NrSlots = 4,
    localparam int unsigned SlotW   = $clog2(NrSlots)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  issue_req_t       issue_req_i,
    output logic             arith_valid_o,
    input  logic             arith_ready_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output issue_req_t       disp_req_o,
    output logic [SlotW-1:0] disp_slot_o,
    input  logic             arith_done_i,
    input  logic             mem_done_i,
    input  logic [SlotW-1:0] arith_done_slot_i,
    input  logic [SlotW-1:0] mem_done_slot_i,
    output logic             commit_valid_o,
    output insn_id_t         commit_insn_id_o,
    output logic             busy_o,
    output logic             protocol_err_o
);

    logic       launch_valid_q, launch_valid_d;
    issue_req_t launch_req_q, launch_req_d;
    logic       lr_is_mem;
    logic       launch_ok;
    logic       launch_fire;
    logic       accept;
    logic       hazard;
    logic       full;
    logic       empty;
`ifdef RVV_LAUNCHER_FLIP_CHECK_EN
    logic       bad_done;
    logic       exp_flip_q, exp_flip_d;
    logic       err_q, err_d;
`endif

    // Dispatch handshake and launch-register next state; valid cannot drop before ready.
    always_comb begin
        lr_is_mem      = is_mem_op(launch_req_q.vop);
        launch_ok      = launch_valid_q && !hazard && !full;
        arith_valid_o  = launch_ok && !lr_is_mem;
        mem_valid_o    = launch_ok && lr_is_mem;
        launch_fire    = (arith_valid_o && arith_ready_i) || (mem_valid_o && mem_ready_i);
        req_ready_o    = !launch_valid_q || launch_fire;
        accept         = req_valid_i && req_ready_o;
        launch_valid_d = launch_valid_q;
        launch_req_d   = launch_req_q;
        if (launch_fire) begin
            launch_valid_d = 1'b0;
        end
        if (accept) begin
            launch_valid_d = 1'b1;
            launch_req_d   = issue_req_i;
        end
    end

    // Launch register valid bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            launch_valid_q <= 1'b0;
        end else begin
            launch_valid_q <= launch_valid_d;
        end
    end

    // Launch register payload, qualified by launch_valid_q so it needs no reset.
    always_ff @(posedge clk_i) begin
        launch_req_q <= launch_req_d;
    end

    assign disp_req_o  = launch_valid_q ? launch_req_q : '0;
    assign busy_o      = launch_valid_q || !empty;

    vinsn_scoreboard #(
        .NrSlots (NrSlots)
    ) u_scoreboard (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .fire_i            (launch_fire),
        .lr_insn_id_i      (launch_req_q.insn_id),
        .lr_vs1_i          (launch_req_q.vs1),
        .lr_vs2_i          (launch_req_q.vs2),
        .lr_vd_i           (launch_req_q.vd),
        .lr_use_vs_i       (launch_req_q.use_vs),
        .lr_use_vd_i       (launch_req_q.use_vd),
        .arith_done_i      (arith_done_i),
        .arith_done_slot_i (arith_done_slot_i),
        .mem_done_i        (mem_done_i),
        .mem_done_slot_i   (mem_done_slot_i),
        .hazard_o          (hazard),
        .full_o            (full),
        .empty_o           (empty),
        .tail_o            (disp_slot_o),
`ifdef RVV_LAUNCHER_FLIP_CHECK_EN
        .bad_done_o        (bad_done),
`endif
        .commit_valid_o    (commit_valid_o),
        .commit_insn_id_o  (commit_insn_id_o)
    );

`ifdef RVV_LAUNCHER_FLIP_CHECK_EN
    // Expected flip bit toggles per accept; any mismatch or stray done latches the error.
    always_comb begin
        exp_flip_d = exp_flip_q;
        err_d      = err_q;
        if (accept) begin
            exp_flip_d = !exp_flip_q;
            if (issue_req_i.flip_bit != exp_flip_q) begin
                err_d = 1'b1;
            end
        end
        if (bad_done) begin
            err_d = 1'b1;
        end
    end

    // Flip checker state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_flip_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            exp_flip_q <= exp_flip_d;
            err_q      <= err_d;
        end
    end

    assign protocol_err_o = err_q;
`else
    assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vinsn_launcher.sv
// tb/tb_vinsn_launcher.sv - directed bench with a queue-based reference model for vinsn_launcher
module tb_vinsn_launcher;
    import core_pkg::*;
    import rvv_pkg::*;

    localparam int N = 4;
`ifdef RVV_LAUNCHER_FLIP_CHECK_EN
    localparam bit FlipEn = 1'b1;
`else
    localparam bit FlipEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    issue_req_t issue_req = '0;
    logic       arith_valid, mem_valid;
    logic       arith_ready = 1'b1;
    logic       mem_ready = 1'b1;
    issue_req_t disp_req;
    logic [1:0] disp_slot;
    logic       arith_done = 1'b0;
    logic       mem_done = 1'b0;
    logic [1:0] arith_slot = '0;
    logic [1:0] mem_slot = '0;
    logic       commit_valid;
    insn_id_t   commit_id;
    logic       busy, perr;

    always #5 clk = ~clk;

    vinsn_launcher #(.NrSlots(N)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .issue_req_i       (issue_req),
        .arith_valid_o     (arith_valid),
        .arith_ready_i     (arith_ready),
        .mem_valid_o       (mem_valid),
        .mem_ready_i       (mem_ready),
        .disp_req_o        (disp_req),
        .disp_slot_o       (disp_slot),
        .arith_done_i      (arith_done),
        .mem_done_i        (mem_done),
        .arith_done_slot_i (arith_slot),
        .mem_done_slot_i   (mem_slot),
        .commit_valid_o    (commit_valid),
        .commit_insn_id_o  (commit_id),
        .busy_o            (busy),
        .protocol_err_o    (perr)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     id;
        int     vd;
        bit     use_vd;
        int     vs1;
        int     vs2;
        bit [1:0] use_vs;
        bit     done;
        int     slot;
    } rec_t;

    rec_t       tq[$];
    bit         lr_v;
    issue_req_t lr_m;
    int         tail_m;
    bit         cv_m;
    int         cid_m;
    bit         err_m;
    bit         exp_flip_m;

    function automatic bit m_haz();
        foreach (tq[i]) begin
            if (!tq[i].done) begin
                if (tq[i].use_vd && ((lr_m.use_vs[0] && tq[i].vd == int'(lr_m.vs1)) ||
                                     (lr_m.use_vs[1] && tq[i].vd == int'(lr_m.vs2)))) return 1'b1;
                if (tq[i].use_vd && lr_m.use_vd && tq[i].vd == int'(lr_m.vd)) return 1'b1;
                if (lr_m.use_vd && ((tq[i].use_vs[0] && tq[i].vs1 == int'(lr_m.vd)) ||
                                    (tq[i].use_vs[1] && tq[i].vs2 == int'(lr_m.vd)))) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit m_mem();
        return (lr_m.vop == VLE) || (lr_m.vop == VSE);
    endfunction

    function automatic bit m_ok();
        return lr_v && !m_haz() && (tq.size() < N);
    endfunction

    function automatic bit m_fire();
        return m_ok() && (m_mem() ? mem_ready : arith_ready);
    endfunction

    function automatic void m_mark(input bit d, input int s);
        bit found;
        found = 1'b0;
        if (d) begin
            foreach (tq[i]) begin
                if (tq[i].slot == s) begin
                    found = 1'b1;
                    tq[i].done = 1'b1;
                end
            end
            if (!found && FlipEn) err_m = 1'b1;
        end
    endfunction

    // Model state advance at each active edge.
    always @(posedge clk) begin
        bit   fire_v, acc_v, ret_v;
        rec_t e;
        if (!rst_n) begin
            tq.delete();
            lr_v = 1'b0;
            tail_m = 0;
            cv_m = 1'b0;
            cid_m = 0;
            err_m = 1'b0;
            exp_flip_m = 1'b0;
        end else begin
            fire_v = m_fire();
            acc_v  = req_valid && (!lr_v || fire_v);
            ret_v  = (tq.size() > 0) && tq[0].done;
            cv_m   = ret_v;
            if (ret_v) cid_m = tq[0].id;
            m_mark(arith_done, int'(arith_slot));
            m_mark(mem_done, int'(mem_slot));
            if (ret_v) void'(tq.pop_front());
            if (fire_v) begin
                e.id = int'(lr_m.insn_id); e.vd = int'(lr_m.vd); e.use_vd = lr_m.use_vd;
                e.vs1 = int'(lr_m.vs1); e.vs2 = int'(lr_m.vs2); e.use_vs = lr_m.use_vs;
                e.done = 1'b0; e.slot = tail_m;
                tq.push_back(e);
                tail_m = (tail_m + 1) % N;
                lr_v = 1'b0;
            end
            if (acc_v) begin
                if (FlipEn && (issue_req.flip_bit != exp_flip_m)) err_m = 1'b1;
                exp_flip_m = !exp_flip_m;
                lr_m = issue_req;
                lr_v = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        bit ok_e, mem_e;
        if (rst_n) begin
            ok_e  = m_ok();
            mem_e = m_mem();
            check("m_req_ready", req_ready, !lr_v || m_fire());
            check("m_arith_valid", arith_valid, ok_e && !mem_e);
            check("m_mem_valid", mem_valid, ok_e && mem_e);
            check("m_commit_valid", commit_valid, cv_m);
            check("m_busy", busy, lr_v || (tq.size() != 0));
            check("m_protocol_err", perr, err_m);
            if (cv_m) check("m_commit_id", commit_id, cid_m);
            if (ok_e) begin
                check("m_disp_slot", disp_slot, tail_m);
                check("m_disp_id", disp_req.insn_id, lr_m.insn_id);
                check("m_disp_vd", disp_req.vd, lr_m.vd);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit nxt_flip = 1'b0;

    function automatic issue_req_t mk(input vop_e op, input int vd, input int vs1, input int vs2,
                                      input bit [1:0] use_vs, input bit use_vd, input int id);
        issue_req_t r;
        r           = '0;
        r.vop       = op;
        r.vd        = vreg_t'(vd);
        r.vs1       = vreg_t'(vs1);
        r.vs2       = vreg_t'(vs2);
        r.use_vs    = use_vs;
        r.use_vd    = use_vd;
        r.vew       = 2'd2;
        r.vlb       = 8'd16;
        r.scalar_op = 32'h1000 + id;
        r.insn_id   = insn_id_t'(id);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_f(input issue_req_t r);
        int n;
        n = 0;
        req_valid = 1'b1;
        issue_req = r;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send(input issue_req_t r);
        r.flip_bit = nxt_flip;
        nxt_flip = !nxt_flip;
        send_f(r);
    endtask

    task automatic pulse_arith(input int s);
        arith_done = 1'b1;
        arith_slot = 2'(s);
        tick();
        arith_done = 1'b0;
    endtask

    task automatic pulse_mem(input int s);
        mem_done = 1'b1;
        mem_slot = 2'(s);
        tick();
        mem_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        arith_done = 1'b0;
        mem_done = 1'b0;
        arith_ready = 1'b1;
        mem_ready = 1'b1;
        nxt_flip = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_arith_valid", arith_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_commit", commit_valid, 0);
        check("rst_perr", perr, 0);
        check("rst_slot", disp_slot, 0);
        tick();
        rst_n = 1'b1;

        // 1: single VADD round trip
        send(mk(VADD, 3, 1, 2, 2'b11, 1'b1, 5));
        @(negedge clk);
        check("t1_arith_valid", arith_valid, 1);
        check("t1_slot", disp_slot, 0);
        check("t1_id", disp_req.insn_id, 5);
        tick();
        @(negedge clk);
        check("t1_valid_drop", arith_valid, 0);
        check("t1_busy", busy, 1);
        tick();
        pulse_arith(0);
        @(negedge clk);
        check("t1_no_commit_yet", commit_valid, 0);
        tick();
        @(negedge clk);
        check("t1_commit", commit_valid, 1);
        check("t1_commit_id", commit_id, 5);
        check("t1_idle", busy, 0);
        tick();
        @(negedge clk);
        check("t1_commit_pulse", commit_valid, 0);
        tick();

        // 2: RAW on a load destination
        do_reset();
        send(mk(VLE, 4, 0, 0, 2'b00, 1'b1, 1));
        send(mk(VADD, 6, 4, 2, 2'b11, 1'b1, 2));
        @(negedge clk);
        check("t2_raw_blocked", arith_valid, 0);
        check("t2_ready_low", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t2_raw_held", arith_valid, 0);
        end
        tick();
        pulse_mem(0);
        @(negedge clk);
        check("t2_released", arith_valid, 1);
        check("t2_slot", disp_slot, 1);
        tick();
        @(negedge clk);
        check("t2_commit_vle", commit_valid, 1);
        check("t2_commit_id", commit_id, 1);
        tick();
        pulse_arith(1);
        tick();
        @(negedge clk);
        check("t2_commit_vadd_id", commit_id, 2);
        tick();

        // 3: table full, then slot reuse after retire
        do_reset();
        for (int i = 0; i < 5; i++) send(mk(VADD, 10 + i, 20, 21, 2'b11, 1'b1, i));
        @(negedge clk);
        check("t3_full_ready", req_ready, 0);
        check("t3_full_valid", arith_valid, 0);
        tick();
        @(negedge clk);
        check("t3_full_held", arith_valid, 0);
        tick();
        pulse_arith(0);
        @(negedge clk);
        check("t3_not_freed_yet", arith_valid, 0);
        tick();
        @(negedge clk);
        check("t3_dispatch", arith_valid, 1);
        check("t3_slot_wrap", disp_slot, 0);
        check("t3_id", disp_req.insn_id, 4);
        check("t3_commit_id", commit_id, 0);
        tick();

        // mid-operation reset drops everything without commits
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_commit", commit_valid, 0);
            check("rst_mid_busy", busy, 0);
            tick();
        end

        // 4: out-of-order completion retires in order on consecutive cycles
        do_reset();
        send(mk(VADD, 1, 20, 21, 2'b11, 1'b1, 0));
        send(mk(VADD, 2, 20, 21, 2'b11, 1'b1, 1));
        tick();
        pulse_arith(1);
        pulse_arith(0);
        @(negedge clk);
        check("t4_wait", commit_valid, 0);
        tick();
        @(negedge clk);
        check("t4_first_id", commit_id, 0);
        check("t4_first_v", commit_valid, 1);
        tick();
        @(negedge clk);
        check("t4_second_id", commit_id, 1);
        check("t4_second_v", commit_valid, 1);
        tick();
        @(negedge clk);
        check("t4_done", commit_valid, 0);
        tick();

        // 5: simultaneous arith/mem completion with a dispatch in the same cycle
        do_reset();
        for (int i = 0; i < 3; i++) send(mk(VADD, 1 + i, 20, 21, 2'b11, 1'b1, i));
        send(mk(VLE, 4, 0, 0, 2'b00, 1'b1, 3));
        tick();
        pulse_arith(0);
        pulse_arith(1);
        arith_ready = 1'b0;
        send(mk(VADD, 5, 20, 21, 2'b11, 1'b1, 4));
        @(negedge clk);
        check("t5_waiting", arith_valid, 1);
        tick();
        arith_ready = 1'b1;
        arith_done = 1'b1;
        arith_slot = 2'd2;
        mem_done = 1'b1;
        mem_slot = 2'd3;
        tick();
        arith_done = 1'b0;
        mem_done = 1'b0;
        @(negedge clk);
        check("t5_fired", arith_valid, 0);
        tick();
        @(negedge clk);
        check("t5_commit2", commit_id, 2);
        tick();
        @(negedge clk);
        check("t5_commit3", commit_id, 3);
        tick();
        @(negedge clk);
        check("t5_still_busy", busy, 1);
        tick();
        pulse_arith(0);
        tick();
        @(negedge clk);
        check("t5_commit4", commit_id, 4);
        check("t5_idle", busy, 0);
        tick();

        // 6: flip-bit protocol error and stray done
        do_reset();
        send_f(mk(VADD, 1, 20, 21, 2'b11, 1'b1, 7));
        send_f(mk(VADD, 2, 20, 21, 2'b11, 1'b1, 8));
        @(negedge clk);
        check("t6_err_set", perr, FlipEn);
        repeat (3) tick();
        @(negedge clk);
        check("t6_err_sticky", perr, FlipEn);
        tick();
        do_reset();
        @(negedge clk);
        check("t6_err_cleared", perr, 0);
        tick();
        pulse_arith(2);
        @(negedge clk);
        check("t6_stray_done", perr, FlipEn);
        tick();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
